// File: rtl/adder_tree_loader.sv
// Operand gather stage for the 8-input adder tree: collects a byte stream into
// groups of N slots and hands each group to the tree as one parallel bundle.
module adder_tree_loader #(
    parameter int WIDTH = 8,
    parameter int N     = 8
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic [WIDTH-1:0]          in_data,
    input  logic                      in_valid,
    input  logic                      in_last,
    output logic                      in_ready,
    output logic [N*WIDTH-1:0]        op_bus,
    output logic [$clog2(N+1)-1:0]    op_count,
    output logic                      op_valid,
    input  logic                      op_ready
);
    localparam int IW = $clog2(N);
    localparam int CW = $clog2(N+1);

    typedef enum logic {FILL, HOLD} state_t;

    state_t                     r_state;
    logic [N-1:0][WIDTH-1:0]    r_gather;
    logic [N-1:0][WIDTH-1:0]    r_op_bus;
    logic [IW-1:0]              r_idx;
    logic [CW-1:0]              r_op_count;
    logic                       r_op_valid;
    logic                       r_in_ready;

    logic [N-1:0][WIDTH-1:0]    w_bundle;
    logic [CW-1:0]              w_count;
    logic                       w_accept;
    logic                       w_close;
    logic                       w_out_free;

    assign w_accept   = in_valid & r_in_ready;
    assign w_close    = (r_idx == IW'(N-1)) | in_last;
    assign w_out_free = ~r_op_valid | op_ready;
    assign w_count    = CW'(r_idx) + CW'(1);

    // Gather slots above idx are always zero because the gather register is
    // cleared on every hand-off, so zero-fill comes for free.
    always_comb begin
        w_bundle = r_gather;
        if (r_state == FILL)
            w_bundle[r_idx] = in_data;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state    <= FILL;
            r_gather   <= '0;
            r_idx      <= '0;
            r_op_bus   <= '0;
            r_op_count <= '0;
            r_op_valid <= 1'b0;
            r_in_ready <= 1'b0;
        end else begin
            if (r_op_valid && op_ready)
                r_op_valid <= 1'b0;
            case (r_state)
                FILL: begin
                    r_in_ready <= 1'b1;
                    if (w_accept) begin
                        if (w_close && w_out_free) begin
                            r_op_bus   <= w_bundle;
                            r_op_count <= w_count;
                            r_op_valid <= 1'b1;
                            r_gather   <= '0;
                            r_idx      <= '0;
                        end else begin
                            r_gather[r_idx] <= in_data;
                            if (w_close) begin
                                // idx is kept so HOLD can derive the count
                                r_state    <= HOLD;
                                r_in_ready <= 1'b0;
                            end else begin
                                r_idx <= r_idx + 1'b1;
                            end
                        end
                    end
                end
                HOLD: begin
                    if (w_out_free) begin
                        r_op_bus   <= w_bundle;
                        r_op_count <= w_count;
                        r_op_valid <= 1'b1;
                        r_gather   <= '0;
                        r_idx      <= '0;
                        r_state    <= FILL;
                        r_in_ready <= 1'b1;
                    end
                end
                default: r_state <= FILL;
            endcase
        end
    end

    assign in_ready = r_in_ready;
    assign op_bus   = r_op_bus;
    assign op_count = r_op_count;
    assign op_valid = r_op_valid;

endmodule

// File: tb/tb_adder_tree_loader.sv
// Scoreboard bench for adder_tree_loader: directed scenarios plus a random
// stream with random backpressure, checked against a queue-based group model.
module tb_adder_tree_loader;
    localparam int N  = 8;
    localparam int W  = 8;
    localparam int CW = $clog2(N+1);

    typedef struct {
        logic [N*W-1:0] bus;
        logic [CW-1:0]  cnt;
    } exp_t;

    logic           clk = 1'b0;
    logic           rst_n;
    logic [W-1:0]   in_data;
    logic           in_valid;
    logic           in_last;
    logic           in_ready;
    logic [N*W-1:0] op_bus;
    logic [CW-1:0]  op_count;
    logic           op_valid;
    logic           op_ready;

    int total = 0;
    int bad   = 0;

    exp_t       sb[$];
    logic [W-1:0] cur[$];
    exp_t       mon_e;

    adder_tree_loader #(.WIDTH(W), .N(N)) dut (
        .clk(clk), .rst_n(rst_n),
        .in_data(in_data), .in_valid(in_valid), .in_last(in_last), .in_ready(in_ready),
        .op_bus(op_bus), .op_count(op_count), .op_valid(op_valid), .op_ready(op_ready)
    );

    always #5 clk = ~clk;

    // Monitor: a handshake seen at the falling edge completes at the next rising edge.
    always @(negedge clk) begin
        if (rst_n && op_valid && op_ready) begin
            total++;
            if (sb.size() == 0) begin
                bad++;
                $display("FAIL unexpected_bundle got bus=%h cnt=%0d want none", op_bus, op_count);
            end else begin
                mon_e = sb.pop_front();
                if (op_bus !== mon_e.bus || op_count !== mon_e.cnt) begin
                    bad++;
                    $display("FAIL bundle got bus=%h cnt=%0d want bus=%h cnt=%0d",
                             op_bus, op_count, mon_e.bus, mon_e.cnt);
                end
            end
        end
    end

    task automatic chk(input string name, input logic [63:0] got, input logic [63:0] want);
        total++;
        if (got !== want) begin
            bad++;
            $display("FAIL %s got=%h want=%h", name, got, want);
        end
    endtask

    // Reference model: a group is whatever bytes arrive until N or in_last.
    task automatic model_accept(input logic [W-1:0] d, input logic l);
        exp_t e;
        cur.push_back(d);
        if (cur.size() == N || l) begin
            e.bus = '0;
            foreach (cur[k]) e.bus[k*W +: W] = cur[k];
            e.cnt = CW'(cur.size());
            sb.push_back(e);
            cur.delete();
        end
    endtask

    task automatic send(input logic [W-1:0] d, input logic l, input bit rnd, output int waits);
        logic rdy;
        bit   done;
        waits = 0;
        done  = 0;
        in_data = d; in_last = l; in_valid = 1'b1;
        while (!done) begin
            @(negedge clk);
            rdy = in_ready;
            @(posedge clk);
            if (rdy) done = 1;
            else begin
                waits++;
                if (waits > 200) begin
                    total++; bad++;
                    $display("FAIL send_timeout got=stalled want=accept");
                    done = 1;
                end
                #1;
                if (rnd) op_ready = 1'($urandom_range(0, 1));
            end
        end
        #1;
        in_valid = 1'b0; in_last = 1'b0;
        if (rdy) model_accept(d, l);
    endtask

    task automatic idle();
        in_valid = 1'b0;
        in_last  = 1'($urandom_range(0, 1));
        in_data  = W'($urandom);
        @(posedge clk);
        #1;
        in_last = 1'b0;
    endtask

    task automatic drain();
        int n;
        n = 0;
        op_ready = 1'b1;
        while (sb.size() > 0 && n < 100) begin
            @(posedge clk);
            #1;
            n++;
        end
        chk("drain_empty", 64'(sb.size()), 64'd0);
    endtask

    initial begin
        int w;
        int stalls;
        logic [N*W-1:0] b1, b2;

        rst_n = 1'b0; in_data = '0; in_valid = 1'b0; in_last = 1'b0; op_ready = 1'b0;
        #2;
        chk("rst_op_valid", 64'(op_valid), 64'd0);
        chk("rst_op_bus", 64'(op_bus), 64'd0);
        chk("rst_op_count", 64'(op_count), 64'd0);
        chk("rst_in_ready", 64'(in_ready), 64'd0);
        #10 rst_n = 1'b1;
        @(posedge clk); #1;
        chk("in_ready_after_rst", 64'(in_ready), 64'd1);

        // Full groups, tree always ready
        op_ready = 1'b1;
        stalls = 0;
        for (int i = 1; i <= 16; i++) begin
            send(W'(i), 1'b0, 1'b0, w);
            stalls += w;
            if (i == 7) chk("no_early_valid", 64'(op_valid), 64'd0);
            if (i == 8 || i == 16) chk("full_latency", 64'(op_valid), 64'd1);
        end
        chk("full_no_stall", 64'(stalls), 64'd0);
        drain();

        // Short group
        send(8'h05, 1'b0, 1'b0, w);
        send(8'h06, 1'b0, 1'b0, w);
        send(8'h07, 1'b1, 1'b0, w);
        chk("short_latency", 64'(op_valid), 64'd1);
        chk("short_bus", 64'(op_bus), 64'h0000_0000_0007_0605);
        chk("short_count", 64'(op_count), 64'd3);
        drain();

        // Single operand
        send(8'hFF, 1'b1, 1'b0, w);
        chk("single_bus", 64'(op_bus), 64'h0000_0000_0000_00FF);
        chk("single_count", 64'(op_count), 64'd1);
        drain();
        idle();

        // Backpressure
        op_ready = 1'b0;
        for (int i = 0; i < N; i++) begin
            b1[i*W +: W] = W'(8'h21 + i);
            b2[i*W +: W] = W'(8'h29 + i);
        end
        for (int i = 0; i < 16; i++) send(W'(8'h21 + i), 1'b0, 1'b0, w);
        chk("bp_in_ready_hold", 64'(in_ready), 64'd0);
        chk("bp_valid_held", 64'(op_valid), 64'd1);
        chk("bp_bus_b1", 64'(op_bus), 64'(b1));
        idle();
        chk("bp_bus_stable", 64'(op_bus), 64'(b1));
        chk("bp_still_hold", 64'(in_ready), 64'd0);
        op_ready = 1'b1;
        @(posedge clk); #1;
        op_ready = 1'b0;
        chk("bp_valid_swap", 64'(op_valid), 64'd1);
        chk("bp_bus_b2", 64'(op_bus), 64'(b2));
        chk("bp_count_b2", 64'(op_count), 64'd8);
        chk("bp_in_ready_back", 64'(in_ready), 64'd1);
        drain();
        idle();

        // Async reset mid-group
        for (int i = 0; i < 4; i++) send(W'(8'hA1 + i), 1'b0, 1'b0, w);
        #2 rst_n = 1'b0;
        #1;
        chk("mid_rst_valid", 64'(op_valid), 64'd0);
        chk("mid_rst_bus", 64'(op_bus), 64'd0);
        chk("mid_rst_count", 64'(op_count), 64'd0);
        chk("mid_rst_in_ready", 64'(in_ready), 64'd0);
        cur.delete();
        #2 rst_n = 1'b1;
        for (int i = 0; i < 8; i++) send(W'(8'h10 + i), 1'b0, 1'b0, w);
        chk("post_rst_valid", 64'(op_valid), 64'd1);
        chk("post_rst_bus", 64'(op_bus), 64'h1716_1514_1312_1110);
        drain();

        // Random stream with random backpressure and noise on idle cycles
        for (int i = 0; i < 300; i++) begin
            op_ready = 1'($urandom_range(0, 1));
            if ($urandom_range(0, 3) == 0) idle();
            send(W'($urandom), 1'($urandom_range(0, 4) == 0), 1'b1, w);
        end
        send(8'h5A, 1'b1, 1'b1, w);
        drain();
        idle();
        chk("model_no_partial", 64'(cur.size()), 64'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout got=running want=finished");
        $fatal(1);
    end

endmodule
